// File: rtl/ccr_pkg.sv
// Shared definitions for the condition code unit: CCR bit positions,
// branch condition selectors and the condition evaluation function.
package ccr_pkg;

    localparam int CCR_WIDTH  = 32;
    localparam int FLAG_WIDTH = 7;

    localparam int CCR_C    = 0;
    localparam int CCR_N    = 1;
    localparam int CCR_V    = 2;
    localparam int CCR_Z    = 3;
    localparam int CCR_INR  = 4;
    localparam int CCR_IFNR = 5;
    localparam int CCR_NOP  = 6;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    // Only C, N, V and Z take part; INR, IFNR and NOP never affect a branch.
    function automatic logic eval_cond(input logic [3:0] code,
                                       input logic [FLAG_WIDTH-1:0] flags);
        logic c, n, v, z;
        logic result;
        c = flags[CCR_C];
        n = flags[CCR_N];
        v = flags[CCR_V];
        z = flags[CCR_Z];
        result = 1'b0;
        case (code)
            COND_EQ: result = z;
            COND_NE: result = ~z;
            COND_CS: result = c;
            COND_CC: result = ~c;
            COND_MI: result = n;
            COND_PL: result = ~n;
            COND_VS: result = v;
            COND_VC: result = ~v;
            COND_HI: result = c & ~z;
            COND_LS: result = ~c | z;
            COND_GE: result = (n == v);
            COND_LT: result = (n != v);
            COND_GT: result = ~z & (n == v);
            COND_LE: result = z | (n != v);
            COND_AL: result = 1'b1;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/ccr_flag_stack.sv
// LIFO of saved CCR flag bytes used across interrupt entry/exit, with
// registered full/empty status and a one-cycle error pulse on illegal requests.
module ccr_flag_stack
    import ccr_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [FLAG_WIDTH-1:0] i_data,
    output logic [FLAG_WIDTH-1:0] o_top,
    output logic                  o_pop_ok,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_error
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [FLAG_WIDTH-1:0] r_mem [STACK_DEPTH];
    logic [PTR_W-1:0]      r_ptr;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_error;

    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic                  w_illegal;
    logic [IDX_W-1:0]      w_top_idx;
    logic [PTR_W-1:0]      w_ptr_next;

    // A simultaneous push and pop is rejected outright rather than treated
    // as a swap, so both requests are dropped together.
    assign w_push_ok = i_push & ~i_pop & ~r_full;
    assign w_pop_ok  = i_pop & ~i_push & ~r_empty;
    assign w_illegal = (i_push & i_pop) | (i_push & ~i_pop & r_full)
                     | (i_pop & ~i_push & r_empty);
    assign w_top_idx = r_ptr[IDX_W-1:0] - IDX_W'(1);

    always_comb begin
        w_ptr_next = r_ptr;
        if (w_push_ok) begin
            w_ptr_next = r_ptr + PTR_W'(1);
        end else if (w_pop_ok) begin
            w_ptr_next = r_ptr - PTR_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr   <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_error <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_ptr   <= w_ptr_next;
            r_full  <= (w_ptr_next == PTR_W'(STACK_DEPTH));
            r_empty <= (w_ptr_next == '0);
            r_error <= w_illegal;
            if (w_push_ok) begin
                r_mem[r_ptr[IDX_W-1:0]] <= i_data;
            end
        end
    end

    assign o_top    = r_mem[w_top_idx];
    assign o_pop_ok = w_pop_ok;
    assign o_full   = r_full;
    assign o_empty  = r_empty;
    assign o_error  = r_error;

endmodule

// File: rtl/condition_code_unit.sv
// Holds the CCR, updates it from the ALU flag bus, explicit writes or the
// save stack, and answers branch-condition queries with a registered result.
module condition_code_unit
    import ccr_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_alu_valid,
    input  logic                  i_nop_flag,
    input  logic                  i_carry_flag,
    input  logic                  i_overflow_flag,
    input  logic                  i_zero_flag,
    input  logic                  i_negative_flag,
    input  logic                  i_inr_flag,
    input  logic                  i_ifnr_flag,
    input  logic                  i_ccr_write,
    input  logic [FLAG_WIDTH-1:0] i_ccr_write_data,
    output logic [CCR_WIDTH-1:0]  o_ccr,
    input  logic                  i_cond_valid,
    input  logic [3:0]            i_cond_code,
    output logic                  o_cond_ready,
    output logic                  o_branch_valid,
    output logic                  o_take_branch,
    input  logic                  i_push,
    input  logic                  i_pop,
    output logic                  o_stack_full,
    output logic                  o_stack_empty,
    output logic                  o_stack_error
);

    logic [FLAG_WIDTH-1:0] r_ccr;
    logic                  r_branch_valid;
    logic                  r_take_branch;

    logic [FLAG_WIDTH-1:0] w_ccr_next;
    logic [FLAG_WIDTH-1:0] w_alu_flags;
    logic [FLAG_WIDTH-1:0] w_stack_top;
    logic                  w_pop_ok;
    logic                  w_accept;

    ccr_flag_stack #(
        .STACK_DEPTH(STACK_DEPTH)
    ) u_stack (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_push   (i_push),
        .i_pop    (i_pop),
        .i_data   (r_ccr),
        .o_top    (w_stack_top),
        .o_pop_ok (w_pop_ok),
        .o_full   (o_stack_full),
        .o_empty  (o_stack_empty),
        .o_error  (o_stack_error)
    );

    assign w_alu_flags = {1'b0, i_ifnr_flag, i_inr_flag, i_zero_flag,
                          i_overflow_flag, i_negative_flag, i_carry_flag};

    always_comb begin
        w_ccr_next = r_ccr;
        if (w_pop_ok) begin
            w_ccr_next = w_stack_top;
        end else if (i_ccr_write) begin
            w_ccr_next = i_ccr_write_data;
        end else if (i_alu_valid) begin
            w_ccr_next = i_nop_flag ? {1'b1, r_ccr[CCR_IFNR:CCR_C]} : w_alu_flags;
        end
    end

    // Any pending CCR source (even a pop that turns out illegal) stalls the
    // query so the registered result is always computed from a settled CCR.
    assign o_cond_ready = ~(i_alu_valid | i_ccr_write | i_pop);
    assign w_accept     = i_cond_valid & o_cond_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ccr          <= '0;
            r_branch_valid <= 1'b0;
            r_take_branch  <= 1'b0;
        end else begin
            r_ccr          <= w_ccr_next;
            r_branch_valid <= w_accept;
            if (w_accept) begin
                r_take_branch <= eval_cond(i_cond_code, r_ccr);
            end
        end
    end

    assign o_ccr          = {{(CCR_WIDTH-FLAG_WIDTH){1'b0}}, r_ccr};
    assign o_branch_valid = r_branch_valid;
    assign o_take_branch  = r_take_branch;

endmodule

// File: tb/tb_condition_code_unit.sv
// Directed bench for condition_code_unit: branch results go through an
// expected queue checked by a monitor; CCR and stack status are checked inline.
module tb_condition_code_unit;
    import ccr_pkg::*;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        nop_flag, carry_flag, overflow_flag, zero_flag;
    logic        negative_flag, inr_flag, ifnr_flag;
    logic        ccr_write;
    logic [6:0]  ccr_write_data;
    logic [31:0] ccr;
    logic        cond_valid;
    logic [3:0]  cond_code;
    logic        cond_ready;
    logic        branch_valid;
    logic        take_branch;
    logic        push, pop;
    logic        stack_full, stack_empty, stack_error;

    int n_checks = 0;
    int n_fails  = 0;

    // Each entry is {condition code, expected take}.
    logic [4:0] exp_q[$];

    condition_code_unit #(.STACK_DEPTH(4)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_alu_valid      (alu_valid),
        .i_nop_flag       (nop_flag),
        .i_carry_flag     (carry_flag),
        .i_overflow_flag  (overflow_flag),
        .i_zero_flag      (zero_flag),
        .i_negative_flag  (negative_flag),
        .i_inr_flag       (inr_flag),
        .i_ifnr_flag      (ifnr_flag),
        .i_ccr_write      (ccr_write),
        .i_ccr_write_data (ccr_write_data),
        .o_ccr            (ccr),
        .i_cond_valid     (cond_valid),
        .i_cond_code      (cond_code),
        .o_cond_ready     (cond_ready),
        .o_branch_valid   (branch_valid),
        .o_take_branch    (take_branch),
        .i_push           (push),
        .i_pop            (pop),
        .o_stack_full     (stack_full),
        .o_stack_empty    (stack_empty),
        .o_stack_error    (stack_error)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && branch_valid) begin
            logic [4:0] e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL branch_unexpected: Branch_Valid=1 got take=%0b, no query outstanding", take_branch);
            end else begin
                e = exp_q.pop_front();
                if (take_branch !== e[0]) begin
                    n_fails++;
                    $display("FAIL branch_cond_%0h: take=%0b expected %0b", e[4:1], take_branch, e[0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alu_valid = 0; nop_flag = 0; carry_flag = 0; overflow_flag = 0;
        zero_flag = 0; negative_flag = 0; inr_flag = 0; ifnr_flag = 0;
        ccr_write = 0; ccr_write_data = '0; push = 0; pop = 0;
    endtask

    // f is in CCR bit order: [0]C [1]N [2]V [3]Z [4]INR [5]IFNR [6]NOP
    task automatic set_alu(input logic [6:0] f);
        alu_valid = 1;
        carry_flag = f[0]; negative_flag = f[1]; overflow_flag = f[2];
        zero_flag = f[3]; inr_flag = f[4]; ifnr_flag = f[5]; nop_flag = f[6];
    endtask

    task automatic alu_op(input logic [6:0] f);
        set_alu(f);
        tick();
        clear_inputs();
    endtask

    task automatic ccr_wr(input logic [6:0] v);
        ccr_write = 1; ccr_write_data = v;
        tick();
        clear_inputs();
    endtask

    task automatic push_op();
        push = 1;
        tick();
        clear_inputs();
    endtask

    task automatic pop_op();
        pop = 1;
        tick();
        clear_inputs();
    endtask

    task automatic query(input logic [3:0] code, input logic exp);
        int n;
        cond_valid = 1; cond_code = code;
        #1;
        n = 0;
        while (!cond_ready && n < 10) begin
            tick();
            n++;
        end
        if (!cond_ready) begin
            n_checks++;
            n_fails++;
            $display("FAIL query_timeout: Cond_Ready=%0b expected 1 within 10 cycles", cond_ready);
        end else begin
            exp_q.push_back({code, exp});
            tick();
        end
        cond_valid = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1; cond_valid = 0; cond_code = '0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #2 rst = 0;
        tick();

        // Reset values
        check("rst_ccr", ccr, 32'h0);
        check("rst_branch_valid", {31'b0, branch_valid}, 32'h0);
        check("rst_take", {31'b0, take_branch}, 32'h0);
        check("rst_empty", {31'b0, stack_empty}, 32'h1);
        check("rst_full", {31'b0, stack_full}, 32'h0);
        check("rst_error", {31'b0, stack_error}, 32'h0);
        check("rst_ready", {31'b0, cond_ready}, 32'h1);

        // Z=1 result, then EQ / NE back to back
        alu_op(7'b000_1000);
        check("alu_z_ccr", ccr, 32'h8);
        query(COND_EQ, 1'b1);
        query(COND_NE, 1'b0);
        tick();
        check("branch_valid_drops", {31'b0, branch_valid}, 32'h0);

        // NOP result only sets bit6
        alu_op(7'b100_0000);
        check("alu_nop_ccr", ccr, 32'h48);

        // N=1, V=0, then NOP: GT/LT/MI/PL/AL/NV ignore bit6
        alu_op(7'b000_0010);
        check("alu_n_ccr", ccr, 32'h2);
        alu_op(7'b100_0000);
        check("alu_nop2_ccr", ccr, 32'h42);
        query(COND_GT, 1'b0);
        query(COND_LT, 1'b1);
        query(COND_MI, 1'b1);
        query(COND_PL, 1'b0);
        query(COND_AL, 1'b1);
        query(COND_NV, 1'b0);

        // Query held during an ALU update stalls and then sees new flags
        cond_valid = 1; cond_code = COND_GE;
        set_alu(7'b000_1001);
        #1;
        check("stall_ready_low", {31'b0, cond_ready}, 32'h0);
        tick();
        clear_inputs();
        #1;
        check("stall_ready_high", {31'b0, cond_ready}, 32'h1);
        check("stall_ccr", ccr, 32'h9);
        exp_q.push_back({COND_GE, 1'b1});
        tick();
        cond_valid = 0;
        query(COND_HI, 1'b0);
        query(COND_LS, 1'b1);
        query(COND_CS, 1'b1);

        // Overflow-only result exercises V-based conditions
        alu_op(7'b011_0100);
        check("alu_v_ccr", ccr, 32'h34);
        query(COND_VS, 1'b1);
        query(COND_LE, 1'b1);
        query(COND_CC, 1'b1);
        query(COND_VC, 1'b0);

        // CCR_Write wins over ALU_Valid
        ccr_write = 1; ccr_write_data = 7'h05;
        set_alu(7'b000_1000);
        tick();
        clear_inputs();
        check("write_prio_ccr", ccr, 32'h5);

        // Pop on empty stack
        pop_op();
        check("pop_empty_error", {31'b0, stack_error}, 32'h1);
        check("pop_empty_ccr", ccr, 32'h5);
        tick();
        check("error_pulse_clears", {31'b0, stack_error}, 32'h0);

        // Fill the stack with distinct values
        ccr_wr(7'h11); push_op();
        ccr_wr(7'h22); push_op();
        ccr_wr(7'h33); push_op();
        check("three_not_full", {31'b0, stack_full}, 32'h0);
        ccr_wr(7'h44); push_op();
        check("four_full", {31'b0, stack_full}, 32'h1);
        check("four_not_empty", {31'b0, stack_empty}, 32'h0);
        ccr_wr(7'h7F);
        push_op();
        check("push_full_error", {31'b0, stack_error}, 32'h1);
        check("push_full_still_full", {31'b0, stack_full}, 32'h1);
        check("push_full_ccr", ccr, 32'h7F);

        // LIFO restore
        pop_op(); check("pop1_ccr", ccr, 32'h44);
        check("pop1_not_full", {31'b0, stack_full}, 32'h0);
        pop_op(); check("pop2_ccr", ccr, 32'h33);
        pop_op(); check("pop3_ccr", ccr, 32'h22);
        check("pop3_not_empty", {31'b0, stack_empty}, 32'h0);
        pop_op(); check("pop4_ccr", ccr, 32'h11);
        check("pop4_empty", {31'b0, stack_empty}, 32'h1);
        check("pop4_no_error", {31'b0, stack_error}, 32'h0);

        // Push stores the pre-update CCR when a write lands in the same cycle
        ccr_wr(7'h0A);
        push = 1; ccr_write = 1; ccr_write_data = 7'h15;
        tick();
        clear_inputs();
        check("push_write_ccr", ccr, 32'h15);
        push_op();
        ccr_wr(7'h3C);

        // Push & Pop together with two entries held
        push = 1; pop = 1;
        tick();
        clear_inputs();
        check("pushpop_error", {31'b0, stack_error}, 32'h1);
        check("pushpop_ccr", ccr, 32'h3C);
        check("pushpop_not_empty", {31'b0, stack_empty}, 32'h0);
        pop_op(); check("after_pushpop_pop", ccr, 32'h15);
        pop_op(); check("after_pushpop_pop2", ccr, 32'h0A);
        check("after_pushpop_empty", {31'b0, stack_empty}, 32'h1);

        // Reset arriving while a branch result is being presented
        push_op();
        ccr_wr(7'h2B);
        cond_valid = 1; cond_code = COND_AL;
        #1;
        exp_q.push_back({COND_AL, 1'b1});
        tick();
        cond_valid = 0;
        check("pre_reset_branch_valid", {31'b0, branch_valid}, 32'h1);
        rst = 1;
        #1;
        exp_q.delete();
        check("mid_rst_branch_valid", {31'b0, branch_valid}, 32'h0);
        check("mid_rst_take", {31'b0, take_branch}, 32'h0);
        check("mid_rst_ccr", ccr, 32'h0);
        check("mid_rst_empty", {31'b0, stack_empty}, 32'h1);
        check("mid_rst_full", {31'b0, stack_full}, 32'h0);
        check("mid_rst_error", {31'b0, stack_error}, 32'h0);
        @(negedge clk);
        rst = 0;
        tick();
        pop_op();
        check("post_rst_pop_error", {31'b0, stack_error}, 32'h1);
        check("post_rst_ccr", ccr, 32'h0);

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/condition_code_unit.md
# condition_code_unit

Consumer of the ALU flag outputs: holds the 32-bit Condition Control Register (CCR), updates it from the flag bus on each valid ALU result, and answers branch-condition queries over a valid/ready handshake with a registered take/not-take result. A 4-entry save/restore stack preserves the CCR across interrupt entry and exit. Sits between the ALU and the control unit's branch and fetch logic.

## Interface
- STACK_DEPTH, 4, number of CCR save slots (power of two, ≥2)
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high; clears all state
- ALU_Valid  in  1  flag bus carries a completed ALU result this cycle
- NOP_FLAG, CARRY_FLAG, OVERFLOW_FLAG, ZERO_FLAG, NEGATIVE_FLAG, INR_FLAG, IFNR_FLAG  in  1 each  ALU flag bus
- CCR_Write  in  1  explicit move-to-CCR
- CCR_WriteData  in  7  new value for CCR[6:0]
- CCR  out  32  registered CCR: [0]C [1]N [2]V [3]Z [4]INR [5]IFNR [6]NOP, [31:7]=0
- Cond_Valid  in  1  branch query present
- Cond_Code  in  4  condition selector
- Cond_Ready  out  1  query accepted when Cond_Valid & Cond_Ready
- Branch_Valid  out  1  one-cycle pulse: Take_Branch is valid
- Take_Branch  out  1  condition result
- Push, Pop  in  1 each  save / restore CCR[6:0]
- Stack_Full, Stack_Empty  out  1 each  stack occupancy status
- Stack_Error  out  1  one-cycle pulse on an illegal stack request

## Operation
- Reset values: CCR=0, Branch_Valid=0, Take_Branch=0, Stack_Empty=1, Stack_Full=0, Stack_Error=0, stack pointer=0.
- CCR update priority, highest first: Pop (legal) > CCR_Write > ALU_Valid. Only the highest active source loads the CCR.
- ALU_Valid & ~NOP_FLAG loads C, N, V, Z, INR, IFNR from the bus and clears bit6.
- ALU_Valid & NOP_FLAG sets bit6 only. Bits [5:0] hold.
- CCR_Write loads CCR[6:0]=CCR_WriteData.
- Push (legal when not full) stores the current pre-update CCR[6:0] and increments the pointer.
- Pop (legal when not empty) decrements the pointer and loads the CCR from the top entry.
- Illegal stack requests are ignored and pulse Stack_Error on the next cycle:
  - Push when full
  - Pop when empty
  - Push & Pop in the same cycle (both ignored, even if each alone would be legal)
- Cond_Ready = ~(ALU_Valid | CCR_Write | Pop). A query stalls while any CCR update is pending, so it never reads a stale CCR.
- Condition codes:
  - 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C
  - 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V
  - 8 HI C&~Z; 9 LS ~C|Z
  - A GE N==V; B LT N!=V; C GT ~Z&(N==V); D LE Z|(N!=V)
  - E AL 1; F NV 0
- Conditions ignore bits 4–6.

## Timing
- CCR update latency: 1 cycle. A source active in cycle t is visible on CCR after edge t+1.
- Branch latency: query accepted at edge t produces Branch_Valid=1 with Take_Branch after edge t (one cycle). Branch_Valid returns to 0 the following cycle unless another query is accepted.
- Back-to-back queries are accepted every cycle while Cond_Ready=1.
- Stack_Full and Stack_Empty are registered and reflect the pointer after each edge.
- Reset asserted mid-query clears a pending Branch_Valid immediately (asynchronous) and empties the stack.

## Structure
- Shared package ccr_pkg:
  - CCR bit indices (CCR_C=0 … CCR_NOP=6)
  - 4-bit condition-code constants (COND_EQ … COND_NV)
  - CCR_WIDTH=32, FLAG_WIDTH=7
- Sub-module ccr_flag_stack (STACK_DEPTH×7 LIFO with full/empty/error) keeps the save/restore logic separable from condition evaluation.

## Test plan
- Reset, then ALU_Valid with Z=1, others 0 -> CCR=32'h8 next cycle; query EQ -> Take_Branch=1 one cycle after acceptance; query NE -> 0.
- ALU_Valid with NOP_FLAG=1 while CCR=32'h8 -> CCR=32'h48; query GT with N=1, V=0 loaded beforehand -> Take_Branch=0.
- Cond_Valid held high during an ALU_Valid cycle -> Cond_Ready=0 in that cycle; query accepted next cycle against the updated flags.
- CCR_Write and ALU_Valid in the same cycle with CCR_WriteData=7'h05 -> CCR=32'h05; then Pop on an empty stack -> Stack_Error pulse, CCR unchanged.
- Push 4 distinct values -> Stack_Full=1; 5th Push -> Stack_Error, no change; 4 Pops restore in LIFO order -> Stack_Empty=1.
- Push & Pop together with 2 entries held -> Stack_Error, pointer and CCR unchanged; assert Reset mid-stream -> all outputs return to their reset values.
